// File: rtl/banked_scalar_reg_file_if.sv
// Package and bus interface for banked_scalar_reg_file.
// The package holds the writeback source selector shared by the design and
// anything that drives it. The interface bundles the issue request, read
// response and writeback buses. DATA_WIDTH defaults to `DATA_WIDTH (16 if
// the macro is not supplied by the build).

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package banked_scalar_reg_file_pkg;
  // Writeback source selector; encodings 5..7 are invalid and raise wb_error.
  typedef enum logic [2:0] {
    ALU_OUT          = 3'd0,
    LSU_OUT          = 3'd1,
    IMMEDIATE        = 3'd2,
    PC_PLUS_1        = 3'd3,
    VECTOR_TO_SCALAR = 3'd4
  } reg_input_mux_t;
endpackage

interface banked_scalar_reg_file_if #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int NUM_WARPS  = 4,
  parameter int NUM_REGS   = 32,
  parameter int PC_WIDTH   = 8
);
  import banked_scalar_reg_file_pkg::*;

  localparam int WARP_W = $clog2(NUM_WARPS);
  localparam int REG_W  = $clog2(NUM_REGS);

  // Issue request / read response
  logic                  req_valid;
  logic                  req_ready;
  logic [WARP_W-1:0]     req_warp_id;
  logic [REG_W-1:0]      req_rs1_addr;
  logic [REG_W-1:0]      req_rs2_addr;
  logic [REG_W-1:0]      req_rd_addr;
  logic                  req_rd_reserve;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rs1;
  logic [DATA_WIDTH-1:0] rs2;

  // Writeback
  logic                  wb_valid;
  logic [WARP_W-1:0]     wb_warp_id;
  logic [REG_W-1:0]      wb_rd_addr;
  reg_input_mux_t        wb_src;
  logic [DATA_WIDTH-1:0] alu_out;
  logic [DATA_WIDTH-1:0] lsu_out;
  logic [DATA_WIDTH-1:0] wb_immediate;
  logic [DATA_WIDTH-1:0] vector_to_scalar_data;
  logic [PC_WIDTH-1:0]   pc;

  // Status
  logic [NUM_WARPS*DATA_WIDTH-1:0] warp_execution_mask;
  logic                            wb_error;

  // Scheduler / writeback side
  modport master (
    output req_valid, req_warp_id, req_rs1_addr, req_rs2_addr, req_rd_addr,
           req_rd_reserve, wb_valid, wb_warp_id, wb_rd_addr, wb_src, alu_out,
           lsu_out, wb_immediate, vector_to_scalar_data, pc,
    input  req_ready, rsp_valid, rs1, rs2, warp_execution_mask, wb_error
  );

  // Register file side
  modport slave (
    input  req_valid, req_warp_id, req_rs1_addr, req_rs2_addr, req_rd_addr,
           req_rd_reserve, wb_valid, wb_warp_id, wb_rd_addr, wb_src, alu_out,
           lsu_out, wb_immediate, vector_to_scalar_data, pc,
    output req_ready, rsp_valid, rs1, rs2, warp_execution_mask, wb_error
  );
endinterface

// File: rtl/banked_scalar_reg_file.sv
// banked_scalar_reg_file: one bank of NUM_REGS scalar registers per warp,
// two registered read ports behind a valid/ready handshake, a per-register
// pending-write scoreboard that stalls RAW/WAW hazards, and a single muxed
// writeback port. Register NUM_REGS-1 of each warp is exported as that
// warp's execution mask.
// Optional feature: define WB_BYPASS_EN to forward a same-cycle writeback
// into both the read data and the req_ready scoreboard check.

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module banked_scalar_reg_file
  import banked_scalar_reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int NUM_WARPS  = 4,
  parameter int NUM_REGS   = 32,
  parameter int PC_WIDTH   = 8
) (
  input logic                     clk,
  input logic                     reset,   // asynchronous, active-low
  banked_scalar_reg_file_if.slave bus
);

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t               regs_q [NUM_WARPS][NUM_REGS];
  word_t               regs_d [NUM_WARPS][NUM_REGS];
  logic [NUM_REGS-1:0] pend_q [NUM_WARPS];
  logic [NUM_REGS-1:0] pend_d [NUM_WARPS];
  logic                rsp_valid_q, rsp_valid_d;
  word_t               rs1_q, rs1_d;
  word_t               rs2_q, rs2_d;
  logic                wb_error_q, wb_error_d;

  word_t               wb_data;
  logic                wb_src_ok;
  logic                wb_write;
  logic [NUM_REGS-1:0] req_pend;
  logic                req_ready;
  logic                accept;
  word_t               rs1_rd, rs2_rd;

  // Writeback source mux; an unknown selector marks the writeback invalid.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    wb_data   = '0;
    wb_src_ok = 1'b1;
    case (bus.wb_src)
      ALU_OUT:          wb_data = bus.alu_out;
      LSU_OUT:          wb_data = bus.lsu_out;
      IMMEDIATE:        wb_data = bus.wb_immediate;
      PC_PLUS_1:        wb_data = DATA_WIDTH'(bus.pc) + DATA_WIDTH'(1);
      VECTOR_TO_SCALAR: wb_data = bus.vector_to_scalar_data;
      default:          wb_src_ok = 1'b0;
    endcase
  end

  // Register 0 is hard-wired: writes to it are dropped here.
  assign wb_write = bus.wb_valid && wb_src_ok && (bus.wb_rd_addr != '0);

  // Scoreboard view of the requesting bank and the resulting ready.
  always_comb begin
    req_pend = pend_q[bus.req_warp_id];
`ifdef WB_BYPASS_EN
    if (wb_write && (bus.wb_warp_id == bus.req_warp_id))
      req_pend[bus.wb_rd_addr] = 1'b0;
`endif
    req_ready = !(req_pend[bus.req_rs1_addr] || req_pend[bus.req_rs2_addr] ||
                  (bus.req_rd_reserve && req_pend[bus.req_rd_addr]));
  end

  assign accept = bus.req_valid && req_ready;

  // Source operand lookup, optionally forwarding the in-flight writeback.
  always_comb begin
    rs1_rd = regs_q[bus.req_warp_id][bus.req_rs1_addr];
    rs2_rd = regs_q[bus.req_warp_id][bus.req_rs2_addr];
`ifdef WB_BYPASS_EN
    if (wb_write && (bus.wb_warp_id == bus.req_warp_id)) begin
      if (bus.wb_rd_addr == bus.req_rs1_addr) rs1_rd = wb_data;
      if (bus.wb_rd_addr == bus.req_rs2_addr) rs2_rd = wb_data;
    end
`endif
  end

  // Next state: writeback clears pending first so a same-cycle reservation wins.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (wb_write) begin
      regs_d[bus.wb_warp_id][bus.wb_rd_addr] = wb_data;
      pend_d[bus.wb_warp_id][bus.wb_rd_addr] = 1'b0;
    end
    if (accept && bus.req_rd_reserve && (bus.req_rd_addr != '0))
      pend_d[bus.req_warp_id][bus.req_rd_addr] = 1'b1;
    rsp_valid_d = accept;
    rs1_d       = accept ? rs1_rd : rs1_q;
    rs2_d       = accept ? rs2_rd : rs2_q;
    wb_error_d  = wb_error_q || (bus.wb_valid && !wb_src_ok);
  end

  // State registers with architectural reset values for every bank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the register array is reset because reg1 and the mask register
      // have defined all-ones reset values that software relies on.
      for (int w = 0; w < NUM_WARPS; w++) begin
        for (int r = 0; r < NUM_REGS; r++)
          regs_q[w][r] <= (r == 1 || r == NUM_REGS - 1) ? '1 : '0;
        pend_q[w] <= '0;
      end
      rsp_valid_q <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      wb_error_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      regs_q      <= regs_d;
      pend_q      <= pend_d;
      rsp_valid_q <= rsp_valid_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      wb_error_q  <= wb_error_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rs1       = rs1_q;
  assign bus.rs2       = rs2_q;
  assign bus.wb_error  = wb_error_q;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_mask
    assign bus.warp_execution_mask[w*DATA_WIDTH +: DATA_WIDTH] = regs_q[w][NUM_REGS-1];
  end

endmodule

// File: tb/tb_banked_scalar_reg_file.sv
// Self-checking bench for banked_scalar_reg_file: directed scenarios followed
// by random traffic, all compared against an array-based reference model.

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module tb_banked_scalar_reg_file;
  import banked_scalar_reg_file_pkg::*;

  localparam int DW = `DATA_WIDTH;
  localparam int NW = 4;
  localparam int NR = 32;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic reset;

  int vectors = 0;
  int errors  = 0;

  banked_scalar_reg_file_if #(.DATA_WIDTH(DW), .NUM_WARPS(NW), .NUM_REGS(NR), .PC_WIDTH(PW)) bus ();

  banked_scalar_reg_file #(.DATA_WIDTH(DW), .NUM_WARPS(NW), .NUM_REGS(NR), .PC_WIDTH(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] m_regs [NW][NR];
  bit            m_pend [NW][NR];
  bit            m_err;
  bit            e_rsp;
  logic [DW-1:0] e_rs1, e_rs2;
  bit            m_wr;
  logic [DW-1:0] m_wdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < NW; w++)
      for (int r = 0; r < NR; r++) begin
        m_regs[w][r] = (r == 1 || r == NR - 1) ? '1 : '0;
        m_pend[w][r] = 0;
      end
    m_err = 0;
    e_rsp = 0;
    e_rs1 = '0;
    e_rs2 = '0;
  endtask

  function automatic bit same_wb(int w, int r);
    return m_wr && (int'(bus.wb_warp_id) == w) && (int'(bus.wb_rd_addr) == r);
  endfunction

  function automatic bit pend_view(int w, int r);
`ifdef WB_BYPASS_EN
    if (same_wb(w, r)) return 0;
`endif
    return m_pend[w][r];
  endfunction

  function automatic logic [DW-1:0] read_view(int w, int r);
    if (r == 0) return '0;
`ifdef WB_BYPASS_EN
    if (same_wb(w, r)) return m_wdata;
`endif
    return m_regs[w][r];
  endfunction

  task automatic check_outputs();
    check("rsp_valid", bus.rsp_valid, e_rsp);
    check("rs1", bus.rs1, e_rs1);
    check("rs2", bus.rs2, e_rs2);
    check("wb_error", bus.wb_error, m_err);
    for (int w = 0; w < NW; w++)
      check($sformatf("mask_w%0d", w), bus.warp_execution_mask[w*DW +: DW], m_regs[w][NR-1]);
  endtask

  // One clock: inputs are already applied at posedge+1.
  task automatic step();
    bit ok, acc, exp_ready;
    int w, a1, a2, ad;
    #2;
    ok = 1;
    case (bus.wb_src)
      ALU_OUT:          m_wdata = bus.alu_out;
      LSU_OUT:          m_wdata = bus.lsu_out;
      IMMEDIATE:        m_wdata = bus.wb_immediate;
      PC_PLUS_1:        m_wdata = DW'(int'(bus.pc) + 1);
      VECTOR_TO_SCALAR: m_wdata = bus.vector_to_scalar_data;
      default:          begin m_wdata = '0; ok = 0; end
    endcase
    m_wr = bus.wb_valid && ok && (bus.wb_rd_addr != 0);
    w  = int'(bus.req_warp_id);
    a1 = int'(bus.req_rs1_addr);
    a2 = int'(bus.req_rs2_addr);
    ad = int'(bus.req_rd_addr);
    exp_ready = !(pend_view(w, a1) || pend_view(w, a2) || (bus.req_rd_reserve && pend_view(w, ad)));
    check("req_ready", bus.req_ready, exp_ready);
    acc = bus.req_valid && exp_ready;
    if (acc) begin
      e_rs1 = read_view(w, a1);
      e_rs2 = read_view(w, a2);
    end
    if (m_wr) begin
      m_regs[bus.wb_warp_id][bus.wb_rd_addr] = m_wdata;
      m_pend[bus.wb_warp_id][bus.wb_rd_addr] = 0;
    end
    if (acc && bus.req_rd_reserve && ad != 0) m_pend[w][ad] = 1;
    if (bus.wb_valid && !ok) m_err = 1;
    e_rsp = acc;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    bus.req_valid = 0; bus.req_warp_id = '0; bus.req_rs1_addr = '0;
    bus.req_rs2_addr = '0; bus.req_rd_addr = '0; bus.req_rd_reserve = 0;
    bus.wb_valid = 0; bus.wb_warp_id = '0; bus.wb_rd_addr = '0; bus.wb_src = ALU_OUT;
    bus.alu_out = '0; bus.lsu_out = '0; bus.wb_immediate = '0;
    bus.vector_to_scalar_data = '0; bus.pc = '0;
  endtask

  task automatic set_req(input bit v, input int w, input int a1, input int a2, input int ad, input bit res);
    bus.req_valid = v; bus.req_warp_id = 2'(w); bus.req_rs1_addr = 5'(a1);
    bus.req_rs2_addr = 5'(a2); bus.req_rd_addr = 5'(ad); bus.req_rd_reserve = res;
  endtask

  task automatic set_wb(input bit v, input int w, input int r, input reg_input_mux_t s);
    bus.wb_valid = v; bus.wb_warp_id = 2'(w); bus.wb_rd_addr = 5'(r); bus.wb_src = s;
  endtask

  // Asynchronous reset entered at the current time, released mid-cycle.
  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #1;
    check_outputs();
    idle();
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #1;
    do_reset();

    // Reset values visible on read: reg1 and reg31 all-ones
    set_req(1, 2, 1, 31, 0, 0);
    step();
    check("t1_rs1", bus.rs1, 16'hFFFF);
    check("t1_rs2", bus.rs2, 16'hFFFF);
    check("t1_mask", bus.warp_execution_mask, 64'hFFFF_FFFF_FFFF_FFFF);

    // Bank isolation
    idle();
    set_wb(1, 1, 5, IMMEDIATE); bus.wb_immediate = 16'h1234;
    step();
    idle();
    set_req(1, 1, 5, 5, 0, 0);
    step();
    check("t2_w1r5", bus.rs1, 16'h1234);
    set_req(1, 0, 5, 5, 0, 0);
    step();
    check("t2_w0r5", bus.rs1, 16'h0000);

    // RAW hazard on a reserved register, resolved by writeback
    set_req(1, 0, 0, 0, 7, 1);
    step();
    set_req(1, 0, 7, 0, 0, 0);
    step();
    set_wb(1, 0, 7, ALU_OUT); bus.alu_out = 16'hABCD;
    step();
    set_wb(0, 0, 0, ALU_OUT);
    step();
    check("t3_r7", bus.rs1, 16'hABCD);

    // Register 0 ignores writes and reservations
    idle();
    set_wb(1, 3, 0, LSU_OUT); bus.lsu_out = 16'hFFFF;
    set_req(1, 3, 0, 0, 0, 1);
    step();
    idle();
    set_req(1, 3, 0, 0, 0, 1);
    step();
    check("t4_r0", bus.rs1, 16'h0000);

    // PC_PLUS_1 does not wrap at PC_WIDTH
    idle();
    set_wb(1, 2, 9, PC_PLUS_1); bus.pc = 8'hFF;
    step();
    idle();
    set_req(1, 2, 9, 9, 0, 0);
    step();
    check("t5_pc1", bus.rs1, 16'h0100);

    // Random traffic, narrow address range to provoke hazards
    for (int i = 0; i < 400; i++) begin
      bus.req_valid      = ($urandom_range(0, 3) != 0);
      bus.req_warp_id    = 2'($urandom_range(0, 3));
      bus.req_rs1_addr   = 5'($urandom_range(0, 7));
      bus.req_rs2_addr   = 5'($urandom_range(0, 7));
      bus.req_rd_addr    = 5'($urandom_range(0, 7));
      bus.req_rd_reserve = ($urandom_range(0, 2) == 0);
      bus.wb_valid       = ($urandom_range(0, 1) == 1);
      bus.wb_warp_id     = ($urandom_range(0, 1) == 1) ? bus.req_warp_id : 2'($urandom_range(0, 3));
      bus.wb_rd_addr     = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      bus.wb_src         = reg_input_mux_t'(3'($urandom_range(0, 4)));
      bus.alu_out        = 16'($urandom);
      bus.lsu_out        = 16'($urandom);
      bus.wb_immediate   = 16'($urandom);
      bus.vector_to_scalar_data = 16'($urandom);
      bus.pc             = 8'($urandom);
      step();
    end

    // Invalid source: no write, sticky error
    idle();
    set_wb(1, 1, 5, reg_input_mux_t'(3'd6)); bus.alu_out = 16'h5A5A;
    step();
    idle();
    set_req(1, 1, 5, 5, 0, 0);
    step();
    step();
    check("t6_err", bus.wb_error, 1'b1);

    // Reset in the middle of reserve-plus-read traffic
    do_reset();
    set_req(1, 0, 3, 4, 6, 1);
    step();
    set_req(1, 0, 6, 1, 8, 1);
    #1;
    do_reset();
    check("t7_rsp", bus.rsp_valid, 1'b0);
    set_req(1, 0, 6, 8, 6, 1);
    step();
    check("t7_ready", bus.rsp_valid, 1'b1);
    check("t7_r6", bus.rs1, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
